// File: rtl/jtcontra_snd_mbox_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtcontra_mbox_pkg : shared constants for the main-to-sound mailbox |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jtcontra_mbox_pkg;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_LATCH = 1;
    localparam int IRQ_PULSE = 2;

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtcontra_snd_mbox_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtcontra_snd_mbox_if : main/sound CPU side signals of the mailbox   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface jtcontra_snd_mbox_if
    import jtcontra_mbox_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int AW = ptr_w(DEPTH);

    logic          main_we;
    logic [DW-1:0] main_din;
    logic          main_flush;
    logic          main_clr_ovf;
    logic          main_full;
    logic          main_ovf;
    logic          main_rd_reply;
    logic [DW-1:0] reply_dout;
    logic          reply_valid;
    logic          snd_rd;
    logic [DW-1:0] snd_dout;
    logic          snd_empty;
    logic          snd_irq;
    logic          snd_irq_ack;
    logic          snd_reply_we;
    logic [DW-1:0] snd_reply_din;
    logic [AW:0]   count;

    modport master (
        output main_we, main_din, main_flush, main_clr_ovf, main_rd_reply,
               snd_rd, snd_irq_ack, snd_reply_we, snd_reply_din,
        input  main_full, main_ovf, reply_dout, reply_valid,
               snd_dout, snd_empty, snd_irq, count
    );

    modport slave (
        input  main_we, main_din, main_flush, main_clr_ovf, main_rd_reply,
               snd_rd, snd_irq_ack, snd_reply_we, snd_reply_din,
        output main_full, main_ovf, reply_dout, reply_valid,
               snd_dout, snd_empty, snd_irq, count
    );

endinterface
`default_nettype wire

// File: rtl/jtcontra_snd_mbox_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtcontra_mbox_fifo : first-word fall-through command FIFO           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtcontra_mbox_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
)(
    input  wire logic          clk,
    input  wire logic          rstn,
    input  wire logic          flush_i,
    input  wire logic          we_i,
    input  wire logic [DW-1:0] din_i,
    input  wire logic          rd_i,
    output logic      [DW-1:0] dout_o,
    output logic               empty_o,
    output logic               full_o,
    output logic      [AW:0]   count_o,
    output logic               wr_acc_o,
    output logic               wr_drop_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          rd_acc;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a full FIFO can still take a write
    assign wr_acc_o  = we_i && !flush_i && (!full_o || rd_i);
    assign wr_drop_o = we_i && !flush_i && full_o && !rd_i;
    assign rd_acc    = rd_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc_o) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc)   rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc_o, rd_acc})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc_o) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/jtcontra_snd_mbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtcontra_snd_mbox : main-to-sound command FIFO, IRQ and reply latch |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtcontra_snd_mbox
    import jtcontra_mbox_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 4,
    parameter int AW       = ptr_w(DEPTH),
    parameter int IRQ_MODE = 1,
    parameter int IRQ_LEN  = 16,
    parameter int REPLY    = 1
)(
    input  wire logic    clk,
    input  wire logic    rstn,
    jtcontra_snd_mbox_if.slave bus
);
    logic wr_acc;
    logic wr_drop;
    logic ovf_q, ovf_d;

    jtcontra_mbox_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush_i   (bus.main_flush),
        .we_i      (bus.main_we),
        .din_i     (bus.main_din),
        .rd_i      (bus.snd_rd),
        .dout_o    (bus.snd_dout),
        .empty_o   (bus.snd_empty),
        .full_o    (bus.main_full),
        .count_o   (bus.count),
        .wr_acc_o  (wr_acc),
        .wr_drop_o (wr_drop)
    );

    // A dropped write outranks a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        if (bus.main_clr_ovf) ovf_d = 1'b0;
        if (wr_drop)          ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign bus.main_ovf = ovf_q;

    generate
        if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
            logic irq_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)               irq_q <= 1'b0;
                else if (bus.main_flush) irq_q <= 1'b0;
                else                     irq_q <= !bus.snd_empty;
            end
            assign bus.snd_irq = irq_q;
        end else if (IRQ_MODE == IRQ_LATCH) begin : g_irq_latch
            logic irq_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)                irq_q <= 1'b0;
                else if (bus.main_flush)  irq_q <= 1'b0;
                else if (wr_acc)          irq_q <= 1'b1;
                else if (bus.snd_irq_ack) irq_q <= 1'b0;
            end
            assign bus.snd_irq = irq_q;
        end else begin : g_irq_pulse
            logic [7:0] pulse_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)                 pulse_q <= 8'd0;
                else if (bus.main_flush)   pulse_q <= 8'd0;
                else if (wr_acc)           pulse_q <= 8'(IRQ_LEN);
                else if (pulse_q != 8'd0)  pulse_q <= pulse_q - 8'd1;
            end
            assign bus.snd_irq = (pulse_q != 8'd0);
        end
    endgenerate

    generate
        if (REPLY != 0) begin : g_reply
            logic [DW-1:0] reply_q;
            logic          valid_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    reply_q <= '0;
                    valid_q <= 1'b0;
                end else if (bus.snd_reply_we) begin
                    reply_q <= bus.snd_reply_din;
                    valid_q <= 1'b1;
                end else if (bus.main_rd_reply) begin
                    valid_q <= 1'b0;
                end
            end
            assign bus.reply_dout  = reply_q;
            assign bus.reply_valid = valid_q;
        end else begin : g_no_reply
            assign bus.reply_dout  = '0;
            assign bus.reply_valid = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_jtcontra_snd_mbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtcontra_snd_mbox : three mailbox variants against a queue model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_jtcontra_snd_mbox;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       we, flush, clr, rdr, rd, ack, rwe;
    logic [7:0] din, rdin;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    jtcontra_snd_mbox_if #(.DW(8), .DEPTH(4)) if_a ();
    jtcontra_snd_mbox_if #(.DW(8), .DEPTH(4)) if_b ();
    jtcontra_snd_mbox_if #(.DW(8), .DEPTH(4)) if_c ();

    assign if_a.main_we = we;  assign if_a.main_din = din;  assign if_a.main_flush = flush;
    assign if_a.main_clr_ovf = clr;  assign if_a.main_rd_reply = rdr;  assign if_a.snd_rd = rd;
    assign if_a.snd_irq_ack = ack;  assign if_a.snd_reply_we = rwe;  assign if_a.snd_reply_din = rdin;
    assign if_b.main_we = we;  assign if_b.main_din = din;  assign if_b.main_flush = flush;
    assign if_b.main_clr_ovf = clr;  assign if_b.main_rd_reply = rdr;  assign if_b.snd_rd = rd;
    assign if_b.snd_irq_ack = ack;  assign if_b.snd_reply_we = rwe;  assign if_b.snd_reply_din = rdin;
    assign if_c.main_we = we;  assign if_c.main_din = din;  assign if_c.main_flush = flush;
    assign if_c.main_clr_ovf = clr;  assign if_c.main_rd_reply = rdr;  assign if_c.snd_rd = rd;
    assign if_c.snd_irq_ack = ack;  assign if_c.snd_reply_we = rwe;  assign if_c.snd_reply_din = rdin;

    jtcontra_snd_mbox #(.DW(8), .DEPTH(4), .IRQ_MODE(1), .IRQ_LEN(16), .REPLY(1))
        u_a (.clk(clk), .rstn(rstn), .bus(if_a.slave));
    jtcontra_snd_mbox #(.DW(8), .DEPTH(4), .IRQ_MODE(2), .IRQ_LEN(4), .REPLY(0))
        u_b (.clk(clk), .rstn(rstn), .bus(if_b.slave));
    jtcontra_snd_mbox #(.DW(8), .DEPTH(4), .IRQ_MODE(0), .IRQ_LEN(16), .REPLY(1))
        u_c (.clk(clk), .rstn(rstn), .bus(if_c.slave));

    // Reference model state
    byte unsigned mq[$];
    bit           m_ovf, m_irql, m_lvl, m_rv;
    int           m_pulse;
    logic [7:0]   m_rd;

    function automatic void model_reset();
        mq.delete();
        m_ovf = 0; m_irql = 0; m_lvl = 0; m_rv = 0; m_pulse = 0; m_rd = 8'h00;
    endfunction

    function automatic void model_step();
        bit full, empty, rd_ok, wr_ok, drop;
        if (rwe) begin m_rd = rdin; m_rv = 1; end
        else if (rdr) m_rv = 0;
        if (flush) begin
            mq.delete();
            m_irql = 0; m_pulse = 0; m_lvl = 0;
            if (clr) m_ovf = 0;
            return;
        end
        full  = (mq.size() == 4);
        empty = (mq.size() == 0);
        rd_ok = rd && !empty;
        wr_ok = we && (!full || rd);
        drop  = we && full && !rd;
        m_lvl = !empty;
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(din);
        if (wr_ok) m_irql = 1; else if (ack) m_irql = 0;
        if (wr_ok) m_pulse = 4; else if (m_pulse > 0) m_pulse--;
        if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a.count"}, if_a.count, mq.size());
        chk({tag, " a.empty"}, if_a.snd_empty, mq.size() == 0);
        chk({tag, " a.full"},  if_a.main_full, mq.size() == 4);
        chk({tag, " a.ovf"},   if_a.main_ovf, m_ovf);
        chk({tag, " a.irq"},   if_a.snd_irq, m_irql);
        chk({tag, " a.rv"},    if_a.reply_valid, m_rv);
        chk({tag, " a.rd"},    if_a.reply_dout, m_rd);
        chk({tag, " b.count"}, if_b.count, mq.size());
        chk({tag, " b.ovf"},   if_b.main_ovf, m_ovf);
        chk({tag, " b.irq"},   if_b.snd_irq, m_pulse != 0);
        chk({tag, " b.rv"},    if_b.reply_valid, 0);
        chk({tag, " b.rd"},    if_b.reply_dout, 0);
        chk({tag, " c.count"}, if_c.count, mq.size());
        chk({tag, " c.irq"},   if_c.snd_irq, m_lvl);
        chk({tag, " c.rd"},    if_c.reply_dout, m_rd);
        if (mq.size() != 0) begin
            chk({tag, " a.dout"}, if_a.snd_dout, mq[0]);
            chk({tag, " b.dout"}, if_b.snd_dout, mq[0]);
            chk({tag, " c.dout"}, if_c.snd_dout, mq[0]);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        we = 0; flush = 0; clr = 0; rdr = 0; rd = 0; ack = 0; rwe = 0;
    endtask

    initial begin
        byte unsigned t1[4];
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        we = 0; flush = 0; clr = 0; rdr = 0; rd = 0; ack = 0; rwe = 0;
        din = 8'h00; rdin = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk) rstn = 1'b1;

        // Fill, overflow, drain
        foreach (t1[i]) begin we = 1; din = t1[i]; step("fill"); end
        chk("t1 full", if_a.main_full, 1);
        chk("t1 count", if_a.count, 4);
        we = 1; din = 8'h55; step("ovf");
        chk("t1 ovf", if_a.main_ovf, 1);
        foreach (t1[i]) begin
            chk("t1 pop", if_a.snd_dout, t1[i]);
            rd = 1; step("pop");
        end
        chk("t1 empty", if_a.snd_empty, 1);

        // Simultaneous write and read on a full FIFO
        clr = 1; step("clr");
        foreach (t1[i]) begin we = 1; din = 8'h70 + 8'(i); step("refill"); end
        we = 1; din = 8'h66; rd = 1; step("full rw");
        chk("t2 count", if_a.count, 4);
        chk("t2 ovf", if_a.main_ovf, 0);
        repeat (3) begin rd = 1; step("pop2"); end
        chk("t2 last", if_a.snd_dout, 8'h66);
        rd = 1; step("pop2");

        // Latched IRQ with acknowledge
        ack = 1; step("ack0");
        we = 1; din = 8'hA5; step("irq wr");
        chk("t3 irq set", if_a.snd_irq, 1);
        we = 1; din = 8'h5A; ack = 1; step("irq wr+ack");
        chk("t3 irq hold", if_a.snd_irq, 1);
        ack = 1; step("irq ack");
        chk("t3 irq clr", if_a.snd_irq, 0);

        // Pulse IRQ length and extension
        flush = 1; step("flush4");
        we = 1; din = 8'h01; step("pulse t0");
        chk("t4 p0", if_b.snd_irq, 1);
        repeat (3) begin step("pulse"); chk("t4 hi", if_b.snd_irq, 1); end
        step("pulse end");
        chk("t4 lo", if_b.snd_irq, 0);
        we = 1; din = 8'h02; step("ext t0");
        step("ext t1");
        we = 1; din = 8'h03; step("ext t2");
        repeat (3) begin step("ext"); chk("t4 ext hi", if_b.snd_irq, 1); end
        step("ext end");
        chk("t4 ext lo", if_b.snd_irq, 0);

        // Reply latch
        rwe = 1; rdin = 8'h3C; step("reply");
        chk("t5 valid", if_a.reply_valid, 1);
        chk("t5 dout", if_a.reply_dout, 8'h3C);
        rwe = 1; rdin = 8'hC3; rdr = 1; step("reply both");
        chk("t5 valid2", if_a.reply_valid, 1);
        chk("t5 dout2", if_a.reply_dout, 8'hC3);
        rdr = 1; step("reply rd");
        chk("t5 hold", if_a.reply_dout, 8'hC3);

        // Flush beats a same-cycle write and leaves ovf alone
        flush = 1; step("flush6");
        repeat (5) begin we = 1; din = 8'($urandom); step("fill6"); end
        flush = 1; we = 1; din = 8'hEE; step("flush+we");
        chk("t6 count", if_a.count, 0);
        chk("t6 ovf", if_a.main_ovf, 1);

        // Asynchronous reset mid-cycle
        repeat (3) begin we = 1; din = 8'($urandom); step("fill async"); end
        chk("t6 pre", if_a.count, 3);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all("async");
        chk("async empty", if_a.snd_empty, 1);
        chk("async ovf", if_a.main_ovf, 0);
        @(negedge clk) rstn = 1'b1;

        // Randomised traffic
        repeat (400) begin
            we    = ($urandom_range(0, 1) == 1);
            din   = 8'($urandom);
            rd    = ($urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 39) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            ack   = ($urandom_range(0, 3) == 0);
            rwe   = ($urandom_range(0, 4) == 0);
            rdin  = 8'($urandom);
            rdr   = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtcontra_snd_mbox.md
Name: jtcontra_snd_mbox

Overview:
Parametrised main-to-sound command mailbox. It replaces the single-byte sound latch plus IRQ wire between the main CPU and the sound CPU in the game top level. It provides a DEPTH-entry command FIFO, a selectable IRQ signalling mode and an optional sound-to-main reply latch. It gives later cores (dual-CPU Konami boards, queued sound commands) one shared block instead of per-game latch logic.

Parameters:
DW, 8, data width of command and reply words
DEPTH, 4, FIFO entries; power of two, 2..64
AW, $clog2(DEPTH), pointer width (derived, do not override)
IRQ_MODE, 1, 0 = level while non-empty, 1 = latched until ack, 2 = fixed-length pulse per write
IRQ_LEN, 16, pulse length in clk cycles for IRQ_MODE 2; range 1..255
REPLY, 1, 1 = reply latch present, 0 = reply outputs tied to 0

Ports:
clk  in  1  system clock (24 MHz domain)
rstn  in  1  asynchronous active-low reset
main_we  in  1  single-cycle write strobe from the main CPU (already cen-qualified)
main_din  in  DW  command word
main_flush  in  1  synchronous FIFO clear
main_clr_ovf  in  1  clears the sticky overflow flag
main_full  out  1  FIFO full
main_ovf  out  1  sticky: a write was dropped
main_rd_reply  in  1  single-cycle reply read strobe
reply_dout  out  DW  reply word
reply_valid  out  1  reply not yet read by main
snd_rd  in  1  single-cycle pop strobe from the sound CPU
snd_dout  out  DW  FIFO head (first-word fall-through)
snd_empty  out  1  FIFO empty
snd_irq  out  1  interrupt to the sound CPU, active high
snd_irq_ack  in  1  IRQ acknowledge (used in mode 1 only)
snd_reply_we  in  1  reply write strobe
snd_reply_din  in  DW  reply word
count  out  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rstn low, asynchronous): pointers=0, count=0, snd_empty=1, main_full=0, main_ovf=0, snd_irq=0, reply_valid=0, reply_dout=0, pulse counter=0. Storage RAM contents are not reset. snd_dout is don't-care while snd_empty=1.
- Write: main_we && !full stores the word at the write pointer. The pointer wraps modulo DEPTH. count increments at that edge.
- Dropped write: main_we && full does not store; main_ovf is set on the next edge.
- Read: snd_rd && !empty advances the read pointer at the edge. snd_dout shows the new head in the following cycle. snd_rd while empty is ignored.
- Simultaneous read and write:
  - Full: both happen; count stays DEPTH; no overflow.
  - Empty: the write happens and the read is ignored.
  - Otherwise: both happen and count is unchanged.
- Write-to-read latency: the written word appears on snd_dout and snd_empty falls 1 cycle after the write edge.
- main_flush: pointers=0, count=0 and the IRQ state is cleared. Flush takes priority over a same-cycle write or read, and the write is discarded without setting ovf. main_ovf is unaffected.
- main_clr_ovf: clears main_ovf. If a dropped write happens in the same cycle, set wins.
- full/empty are derived from count, so there is no pointer-equality ambiguity.
- IRQ_MODE 0: snd_irq is a register that tracks !empty one cycle late.
- IRQ_MODE 1:
  - An irq flag is set by an accepted write and cleared by snd_irq_ack.
  - If an accepted write and an ack occur in the same cycle, the flag stays set.
  - An ack while the flag is clear has no effect.
- IRQ_MODE 2:
  - Each accepted write loads the counter with IRQ_LEN; snd_irq = (counter != 0); the counter decrements to 0.
  - A write during a pulse reloads the counter, extending the pulse.
- Reply latch (REPLY=1):
  - snd_reply_we loads reply_dout and sets reply_valid.
  - main_rd_reply clears reply_valid.
  - If both occur in the same cycle, the new data is loaded and reply_valid stays 1.
  - reply_dout holds its value after the read.
- Reply latch (REPLY=0): reply_dout=0 and reply_valid=0.
- All state changes on the rising edge of clk. There are no combinational paths from inputs to outputs except snd_dout from RAM read-address selection.

Decomposition:
- Package jtcontra_mbox_pkg holds the IRQ_MODE localparams (IRQ_LEVEL=0, IRQ_LATCH=1, IRQ_PULSE=2) and a function for the pointer width.
- One sub-module, jtcontra_mbox_fifo (storage, pointers, count, full/empty).
- IRQ logic and the reply latch stay in the top.

Test Plan:
1. Reset, then DEPTH=4: write 11,22,33,44 → main_full=1, count=4. A fifth write (55) → main_ovf=1 and the contents are unchanged. Pop 4 → snd_dout reads 11,22,33,44, then snd_empty=1.
2. Full FIFO, simultaneous main_we(66) and snd_rd → count stays 4, ovf stays 0. The last popped word is 66.
3. IRQ_MODE 1: write A5 → snd_irq=1 the next cycle. Ack in the same cycle as a write of 5A → snd_irq stays 1. A lone ack → snd_irq=0.
4. IRQ_MODE 2, IRQ_LEN=4: write at t0 → snd_irq high for exactly 4 cycles. A write at t2 → the pulse ends 4 cycles after t2.
5. Reply: snd_reply_we(3C) → reply_valid=1, reply_dout=3C. Same-cycle main_rd_reply and snd_reply_we(C3) → valid=1, dout=C3.
6. Mid-operation: count=3 with rstn pulled low asynchronously → all outputs are at reset values without a clock edge. main_flush together with main_we → count=0 and main_ovf is unchanged.
